otp_keystream_xor: RTL

OTP_KEYSTREAM_XOR -- requirements
Module: otp_keystream_xor

---
 rtl/otp_pkg.sv | 19 +
 rtl/otp_keystream_xor.sv | 119 +++++++++++
 2 files changed

// File: rtl/otp_pkg.sv
// rtl/otp_pkg.sv - shared types and constants for the OTP keystream XOR block
package otp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_READY   = 2'd2,
    ST_ADVANCE = 2'd3
  } otp_state_e;

  localparam int          OTP_BYTE_W    = 8;
  localparam logic [7:0]  ZERO_SEED_SUB = 8'hFF;

  // LFSR command encoding is {s0, s1}
  localparam logic [1:0]  LFSR_LOAD = 2'b11;
  localparam logic [1:0]  LFSR_SHL  = 2'b10;
  localparam logic [1:0]  LFSR_HOLD = 2'b00;

endpackage

// File: rtl/otp_keystream_xor.sv
// rtl/otp_keystream_xor.sv - XORs a byte stream with keystream from an external 8-bit LFSR
module otp_keystream_xor
  import otp_pkg::*;
#(
  parameter int ADV_SHIFTS = 8,
  parameter int CNT_W      = 16
) (
  input  logic                  i_clk,
  input  logic                  i_clear_n,
  input  logic                  i_seed_valid,
  input  logic [OTP_BYTE_W-1:0] i_seed,
  output logic                  o_seed_ready,
  input  logic                  i_din_valid,
  input  logic [OTP_BYTE_W-1:0] i_din,
  output logic                  o_din_ready,
  output logic                  o_dout_valid,
  output logic [OTP_BYTE_W-1:0] o_dout,
  input  logic                  i_dout_ready,
  output logic                  o_lfsr_s0,
  output logic                  o_lfsr_s1,
  output logic [OTP_BYTE_W-1:0] o_lfsr_in,
  input  logic [OTP_BYTE_W-1:0] i_lfsr_q,
  output logic [CNT_W-1:0]      o_byte_cnt,
  output logic                  o_seed_err
);

  localparam logic [3:0]       ADV_LAST = 4'(ADV_SHIFTS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  otp_state_e            r_state;
  logic [3:0]            r_adv_cnt;
  logic [1:0]            r_lfsr_cmd;
  logic [OTP_BYTE_W-1:0] r_lfsr_in;
  logic [OTP_BYTE_W-1:0] r_dout;
  logic                  r_dout_valid;
  logic [CNT_W-1:0]      r_byte_cnt;
  logic                  r_seed_err;

  logic w_seed_ready;
  logic w_seed_go;
  logic w_din_ready;
  logic w_accept;
  logic w_seed_zero;

  assign w_seed_ready = (r_state == ST_IDLE) || (r_state == ST_READY);
  assign w_seed_go    = i_seed_valid && w_seed_ready;
  // A pending seed blocks data so the byte is never XORed with a stale key
  assign w_din_ready  = (r_state == ST_READY) && !i_seed_valid &&
                        (!r_dout_valid || i_dout_ready);
  assign w_accept     = i_din_valid && w_din_ready;
  assign w_seed_zero  = (i_seed == '0);

  always_ff @(posedge i_clk or negedge i_clear_n) begin
    if (!i_clear_n) begin
      r_state      <= ST_IDLE;
      r_adv_cnt    <= 4'd0;
      r_lfsr_cmd   <= LFSR_HOLD;
      r_lfsr_in    <= '0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_byte_cnt   <= '0;
      r_seed_err   <= 1'b0;
    end else begin
      r_seed_err <= 1'b0;
      if (r_dout_valid && i_dout_ready) begin
        r_dout_valid <= 1'b0;
      end
      if (w_seed_go) begin
        r_state    <= ST_LOAD;
        r_lfsr_cmd <= LFSR_LOAD;
        r_lfsr_in  <= w_seed_zero ? ZERO_SEED_SUB : i_seed;
        r_seed_err <= w_seed_zero;
        r_byte_cnt <= '0;
      end else begin
        case (r_state)
          ST_LOAD: begin
            r_state    <= ST_READY;
            r_lfsr_cmd <= LFSR_HOLD;
          end
          ST_READY: begin
            if (w_accept) begin
              r_dout       <= i_din ^ i_lfsr_q;
              r_dout_valid <= 1'b1;
              if (r_byte_cnt != '1) begin
                r_byte_cnt <= r_byte_cnt + CNT_ONE;
              end
              r_adv_cnt  <= 4'd0;
              r_state    <= ST_ADVANCE;
              r_lfsr_cmd <= LFSR_SHL;
            end
          end
          ST_ADVANCE: begin
            if (r_adv_cnt == ADV_LAST) begin
              r_state    <= ST_READY;
              r_lfsr_cmd <= LFSR_HOLD;
            end else begin
              r_adv_cnt <= r_adv_cnt + 4'd1;
            end
          end
          default: begin
            r_state    <= ST_IDLE;
            r_lfsr_cmd <= LFSR_HOLD;
          end
        endcase
      end
    end
  end

  assign o_seed_ready = w_seed_ready;
  assign o_din_ready  = w_din_ready;
  assign o_dout_valid = r_dout_valid;
  assign o_dout       = r_dout;
  assign o_lfsr_s0    = r_lfsr_cmd[1];
  assign o_lfsr_s1    = r_lfsr_cmd[0];
  assign o_lfsr_in    = r_lfsr_in;
  assign o_byte_cnt   = r_byte_cnt;
  assign o_seed_err   = r_seed_err;

endmodule
